axis_tx_serializer: RTL and testbench

AXIS_TX_SERIALIZER -- requirements
Module: axis_tx_serializer

---
 rtl/axis_tx_serializer.sv | 174 +++++++++++++++++
 tb/tb_axis_tx_serializer.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_tx_serializer.sv
// Wide-to-byte AXI-Stream serializer: holds one input word and emits its kept
// bytes in lane order, with frame abort (m_drop) and single-cycle status pulses.
module axis_tx_serializer #(
  parameter int S_DATA_WIDTH = 32,
  parameter int S_KEEP_WIDTH = S_DATA_WIDTH / 8,
  parameter int USER_WIDTH   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [USER_WIDTH-1:0]   s_axis_tuser,
  output logic [7:0]              m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [USER_WIDTH-1:0]   m_axis_tuser,
  input  logic                    m_drop,
  output logic                    status_frame_done,
  output logic                    status_frame_dropped,
  output logic                    status_null_word
);

  localparam int IDX_W = (S_KEEP_WIDTH > 1) ? $clog2(S_KEEP_WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_SEND,
    ST_DROP
  } state_t;

  state_t                  state_q;
  logic [S_DATA_WIDTH-1:0] data_q;
  logic [S_KEEP_WIDTH-1:0] keep_q;
  logic                    last_q;
  logic [USER_WIDTH-1:0]   user_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    in_frame_q;
  logic                    rdy_q;
  logic                    done_q;
  logic                    dropped_q;
  logic                    null_q;

  logic [IDX_W-1:0]        first_idx;
  logic [IDX_W-1:0]        next_idx;
  logic                    has_next;
  logic                    final_byte;
  logic                    s_hs;
  logic                    m_hs;
  logic                    s_null;

  always_comb begin
    first_idx = '0;
    next_idx  = '0;
    has_next  = 1'b0;
    // Scan downward so the last hit is the lowest qualifying lane.
    for (int unsigned i = S_KEEP_WIDTH; i > 0; i--) begin
      if (s_axis_tkeep[i-1]) begin
        first_idx = IDX_W'(i - 1);
      end
      if (keep_q[i-1] && (IDX_W'(i - 1) > idx_q)) begin
        next_idx = IDX_W'(i - 1);
        has_next = 1'b1;
      end
    end
  end

  assign final_byte = !has_next;

  always_comb begin
    s_axis_tready = 1'b0;
    case (state_q)
      ST_EMPTY: s_axis_tready = rdy_q;
      // An abort overrides the handshake, so the final byte is not consumed.
      ST_SEND:  s_axis_tready = m_axis_tready && final_byte && !m_drop;
      ST_DROP:  s_axis_tready = 1'b1;
      default:  s_axis_tready = 1'b0;
    endcase
  end

  assign m_axis_tvalid = (state_q == ST_SEND);
  assign m_axis_tdata  = m_axis_tvalid ? data_q[{idx_q, 3'b000} +: 8] : '0;
  assign m_axis_tlast  = m_axis_tvalid && last_q && final_byte;
  assign m_axis_tuser  = m_axis_tlast ? user_q : '0;

  assign s_hs   = s_axis_tvalid && s_axis_tready;
  assign m_hs   = m_axis_tvalid && m_axis_tready && !m_drop;
  assign s_null = (s_axis_tkeep == '0);

  assign status_frame_done    = done_q;
  assign status_frame_dropped = dropped_q;
  assign status_null_word     = null_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      data_q     <= '0;
      keep_q     <= '0;
      last_q     <= 1'b0;
      user_q     <= '0;
      idx_q      <= '0;
      in_frame_q <= 1'b0;
      rdy_q      <= 1'b0;
      done_q     <= 1'b0;
      dropped_q  <= 1'b0;
      null_q     <= 1'b0;
    end else begin
      rdy_q     <= 1'b1;
      done_q    <= 1'b0;
      dropped_q <= 1'b0;
      null_q    <= s_hs && s_null;
      if (s_hs) begin
        in_frame_q <= !s_axis_tlast;
      end
      case (state_q)
        ST_EMPTY: begin
          if (m_drop && in_frame_q) begin
            // A word accepted alongside the abort belongs to the aborted frame.
            in_frame_q <= 1'b0;
            if (s_hs && s_axis_tlast) begin
              dropped_q <= 1'b1;
            end else begin
              state_q <= ST_DROP;
            end
          end else if (s_hs && !s_null) begin
            data_q  <= s_axis_tdata;
            keep_q  <= s_axis_tkeep;
            last_q  <= s_axis_tlast;
            user_q  <= s_axis_tuser;
            idx_q   <= first_idx;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (m_drop) begin
            in_frame_q <= 1'b0;
            if (last_q) begin
              dropped_q <= 1'b1;
              state_q   <= ST_EMPTY;
            end else begin
              state_q <= ST_DROP;
            end
          end else if (m_hs) begin
            if (final_byte) begin
              done_q <= last_q;
              if (s_hs && !s_null) begin
                data_q <= s_axis_tdata;
                keep_q <= s_axis_tkeep;
                last_q <= s_axis_tlast;
                user_q <= s_axis_tuser;
                idx_q  <= first_idx;
              end else begin
                state_q <= ST_EMPTY;
              end
            end else begin
              idx_q <= next_idx;
            end
          end
        end
        ST_DROP: begin
          if (s_hs && s_axis_tlast) begin
            dropped_q <= 1'b1;
            state_q   <= ST_EMPTY;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_tx_serializer.sv
// Self-checking bench for axis_tx_serializer: directed scenarios plus randomized
// frames compared against a lane-order byte model.
module tb_axis_tx_serializer;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [0:0]  s_axis_tuser;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [0:0]  m_axis_tuser;
  logic        m_drop;
  logic        status_frame_done;
  logic        status_frame_dropped;
  logic        status_null_word;

  int errors = 0;
  int checks = 0;

  word_t       in_q[$];
  logic [9:0]  exp_q[$];
  logic [9:0]  out_q[$];
  int          out_cyc[$];
  int          in_cyc[$];
  int          cyc = 0;
  int          done_cnt, dropped_cnt, null_cnt, done_cyc;
  int          stall_viol;

  always #5 clk = ~clk;

  axis_tx_serializer #(
    .S_DATA_WIDTH(32),
    .S_KEEP_WIDTH(4),
    .USER_WIDTH(1)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .s_axis_tdata        (s_axis_tdata),
    .s_axis_tkeep        (s_axis_tkeep),
    .s_axis_tvalid       (s_axis_tvalid),
    .s_axis_tready       (s_axis_tready),
    .s_axis_tlast        (s_axis_tlast),
    .s_axis_tuser        (s_axis_tuser),
    .m_axis_tdata        (m_axis_tdata),
    .m_axis_tvalid       (m_axis_tvalid),
    .m_axis_tready       (m_axis_tready),
    .m_axis_tlast        (m_axis_tlast),
    .m_axis_tuser        (m_axis_tuser),
    .m_drop              (m_drop),
    .status_frame_done   (status_frame_done),
    .status_frame_dropped(status_frame_dropped),
    .status_null_word    (status_null_word)
  );

  // Observer: logs transfers and status pulses mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_axis_tvalid && m_axis_tready && !m_drop) begin
        out_q.push_back({m_axis_tlast, m_axis_tuser, m_axis_tdata});
        out_cyc.push_back(cyc);
      end
      if (s_axis_tvalid && s_axis_tready) in_cyc.push_back(cyc);
      if (status_frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (status_frame_dropped) dropped_cnt++;
      if (status_null_word) null_cnt++;
    end
    cyc++;
  end

  function automatic word_t mk(input logic [31:0] d, input logic [3:0] k,
                               input logic l, input logic u);
    word_t w;
    w.data = d; w.keep = k; w.last = l; w.user = u;
    return w;
  endfunction

  // Reference: every kept lane in ascending order; tlast/tuser only on the
  // highest kept lane of a last word.
  function automatic void build_expected();
    exp_q.delete();
    foreach (in_q[w]) begin
      int hi = -1;
      for (int l = 0; l < 4; l++) if (in_q[w].keep[l]) hi = l;
      for (int l = 0; l < 4; l++) begin
        if (in_q[w].keep[l]) begin
          logic tl;
          tl = in_q[w].last && (l == hi);
          exp_q.push_back({tl, tl & in_q[w].user, in_q[w].data[l*8 +: 8]});
        end
      end
    end
  endfunction

  task automatic clear_log();
    out_q.delete(); out_cyc.delete(); in_cyc.delete();
    done_cnt = 0; dropped_cnt = 0; null_cnt = 0; done_cyc = -1; stall_viol = 0;
  endtask

  // Drives in_q word by word; asserts m_drop for one cycle once drop_at bytes
  // have been transferred (drop_at < 0 disables).
  task automatic drive_words(input int ready_pct, input int drop_at, output bit ok);
    int  i = 0;
    int  n = 0;
    int  tail = 0;
    bit  drop_used = 0;
    bit  hs;
    bit  prev_stall = 0;
    logic [7:0] prev_data = '0;
    logic       prev_user = 1'b0;
    ok = 1;
    while (1) begin
      if (i < in_q.size()) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = in_q[i].data;
        s_axis_tkeep  = in_q[i].keep;
        s_axis_tlast  = in_q[i].last;
        s_axis_tuser  = in_q[i].user;
      end else begin
        s_axis_tvalid = 1'b0;
      end
      m_axis_tready = ($urandom_range(99) < ready_pct);
      m_drop = (drop_at >= 0) && !drop_used && (out_q.size() == drop_at);
      if (m_drop) drop_used = 1;
      @(negedge clk);
      hs = s_axis_tvalid && s_axis_tready;
      if (prev_stall && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data ||
                         m_axis_tuser[0] !== prev_user))
        stall_viol++;
      prev_stall = m_axis_tvalid && !m_axis_tready && !m_drop;
      prev_data  = m_axis_tdata;
      prev_user  = m_axis_tuser[0];
      if (i >= in_q.size() && !m_axis_tvalid) tail++;
      @(posedge clk); #1;
      if (hs) i++;
      n++;
      if (n > 20000) begin ok = 0; break; end
      if (tail >= 3) break;
    end
    s_axis_tvalid = 1'b0;
    m_drop        = 1'b0;
    m_axis_tready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: tready=%b tvalid=%b tlast=%b tuser=%b tdata=%h, want all zero",
               s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata);
    end
    checks++;
    if ({status_frame_done, status_frame_dropped, status_null_word} !== 3'b000) begin
      errors++;
      $display("FAIL reset_status: got %b%b%b want 000", status_frame_done,
               status_frame_dropped, status_null_word);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (s_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL reset_tready_hold: got %b want 0", s_axis_tready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_tready_rise: got %b want 1", s_axis_tready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_word();
    bit ok;
    clear_log();
    in_q = '{mk(32'h44332211, 4'hF, 1'b1, 1'b0)};
    build_expected();
    drive_words(100, -1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout: got timeout want completion"); end
    checks++;
    if (out_q.size() != 4) begin
      errors++; $display("FAIL single_count: got %0d want 4", out_q.size());
    end else begin
      foreach (exp_q[k]) begin
        checks++;
        if (out_q[k] !== exp_q[k]) begin
          errors++; $display("FAIL single_byte%0d: got %h want %h", k, out_q[k], exp_q[k]);
        end
      end
      checks++;
      if (in_cyc.size() != 1 || out_cyc[0] != in_cyc[0] + 1) begin
        errors++; $display("FAIL single_latency: got out@%0d in@%0d want 1 cycle", out_cyc[0],
                           (in_cyc.size() > 0) ? in_cyc[0] : -1);
      end
      checks++;
      if (out_cyc[3] - out_cyc[0] != 3) begin
        errors++; $display("FAIL single_consecutive: got span %0d want 3", out_cyc[3] - out_cyc[0]);
      end
      checks++;
      if (done_cnt != 1 || done_cyc != out_cyc[3] + 1) begin
        errors++; $display("FAIL single_done: got cnt=%0d at %0d want 1 at %0d", done_cnt, done_cyc,
                           out_cyc[3] + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_log();
    in_q = '{mk(32'h04030201, 4'hF, 1'b0, 1'b0), mk(32'h08070605, 4'h3, 1'b1, 1'b0)};
    build_expected();
    drive_words(100, -1, ok);
    checks++;
    if (!ok || out_q.size() != 6) begin
      errors++; $display("FAIL b2b_count: got %0d bytes ok=%0d want 6", out_q.size(), ok);
    end else begin
      foreach (exp_q[k]) begin
        checks++;
        if (out_q[k] !== exp_q[k]) begin
          errors++; $display("FAIL b2b_byte%0d: got %h want %h", k, out_q[k], exp_q[k]);
        end
      end
      checks++;
      if (out_cyc[5] - out_cyc[0] != 5) begin
        errors++; $display("FAIL b2b_bubble: got span %0d want 5", out_cyc[5] - out_cyc[0]);
      end
    end
  endtask

  task automatic test_sparse_keep();
    bit ok;
    clear_log();
    in_q = '{mk(32'hDDCCBBAA, 4'h5, 1'b1, 1'b1)};
    build_expected();
    drive_words(100, -1, ok);
    checks++;
    if (!ok || out_q.size() != 2) begin
      errors++; $display("FAIL sparse_count: got %0d bytes want 2", out_q.size());
    end else begin
      checks++;
      if (out_q[0] !== 10'h0AA) begin
        errors++; $display("FAIL sparse_first: got %h want 0aa", out_q[0]);
      end
      checks++;
      if (out_q[1] !== 10'h3CC) begin
        errors++; $display("FAIL sparse_last: got %h want 3cc", out_q[1]);
      end
    end
  endtask

  task automatic test_null_word();
    bit ok;
    clear_log();
    in_q = '{mk(32'h12345678, 4'h0, 1'b1, 1'b0)};
    drive_words(100, -1, ok);
    checks++;
    if (!ok || out_q.size() != 0) begin
      errors++; $display("FAIL null_output: got %0d bytes want 0", out_q.size());
    end
    checks++;
    if (null_cnt != 1 || done_cnt != 0) begin
      errors++; $display("FAIL null_pulse: got null=%0d done=%0d want 1 0", null_cnt, done_cnt);
    end
  endtask

  task automatic test_drop();
    bit ok;
    clear_log();
    in_q = '{mk(32'h04030201, 4'hF, 1'b0, 1'b0), mk(32'h08070605, 4'hF, 1'b0, 1'b0),
             mk(32'h0C0B0A09, 4'hF, 1'b1, 1'b0)};
    drive_words(100, 1, ok);
    checks++;
    if (!ok || out_q.size() != 1 || out_q[0] !== 10'h001) begin
      errors++; $display("FAIL drop_output: got %0d bytes first=%h want 1 byte 001", out_q.size(),
                         (out_q.size() > 0) ? out_q[0] : 10'h3FF);
    end
    checks++;
    if (in_cyc.size() != 3) begin
      errors++; $display("FAIL drop_consume: got %0d words want 3", in_cyc.size());
    end
    checks++;
    if (dropped_cnt != 1 || done_cnt != 0) begin
      errors++; $display("FAIL drop_pulse: got dropped=%0d done=%0d want 1 0", dropped_cnt, done_cnt);
    end
    clear_log();
    m_drop = 1'b1;
    repeat (2) begin @(negedge clk); @(posedge clk); #1; end
    m_drop = 1'b0;
    @(negedge clk); @(posedge clk); #1;
    checks++;
    if (dropped_cnt != 0) begin
      errors++; $display("FAIL drop_idle: got %0d pulses want 0", dropped_cnt);
    end
    in_q = '{mk(32'h44332211, 4'hF, 1'b1, 1'b0)};
    build_expected();
    drive_words(100, -1, ok);
    checks++;
    if (!ok || out_q.size() != 4) begin
      errors++; $display("FAIL drop_next_count: got %0d want 4", out_q.size());
    end else begin
      foreach (exp_q[k]) begin
        checks++;
        if (out_q[k] !== exp_q[k]) begin
          errors++; $display("FAIL drop_next_byte%0d: got %h want %h", k, out_q[k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    clear_log();
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'hA1B2C3D4; s_axis_tkeep = 4'h8;
    s_axis_tlast = 1'b1; s_axis_tuser = 1'b1; m_axis_tready = 1'b0;
    @(negedge clk); @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata} !== 11'h7A1) begin
      errors++; $display("FAIL midreset_held: got v=%b l=%b u=%b d=%h want 1 1 1 a1",
                         m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata,
         status_frame_done, status_frame_dropped, status_null_word} !== 15'h0) begin
      errors++; $display("FAIL midreset_outputs: got r=%b v=%b l=%b u=%b d=%h st=%b%b%b want zero",
                         s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata,
                         status_frame_done, status_frame_dropped, status_null_word);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_axis_tready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      errors++; $display("FAIL midreset_after: got tready=%b tvalid=%b want 1 0",
                         s_axis_tready, m_axis_tvalid);
    end
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (done_cnt + dropped_cnt + null_cnt != 0 || out_q.size() != 0) begin
      errors++; $display("FAIL midreset_lost: got %0d pulses %0d bytes want 0 0",
                         done_cnt + dropped_cnt + null_cnt, out_q.size());
    end
  endtask

  task automatic test_random();
    bit ok;
    int exp_done = 0;
    int exp_null = 0;
    clear_log();
    in_q.delete();
    for (int f = 0; f < 100; f++) begin
      int nw = $urandom_range(4, 1);
      for (int w = 0; w < nw; w++) begin
        int r = $urandom_range(9);
        logic [3:0] k;
        logic l;
        k = (r == 0) ? 4'h0 : (r < 5) ? 4'hF : 4'($urandom_range(15, 1));
        l = (w == nw - 1);
        in_q.push_back(mk($urandom, k, l, 1'($urandom_range(1))));
        if (k == 4'h0) exp_null++;
        else if (l) exp_done++;
      end
    end
    build_expected();
    drive_words(60, -1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL random_timeout: got timeout want completion"); end
    checks++;
    if (out_q.size() != exp_q.size()) begin
      errors++; $display("FAIL random_count: got %0d want %0d", out_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[k]) begin
        checks++;
        if (out_q[k] !== exp_q[k]) begin
          errors++; $display("FAIL random_byte%0d: got %h want %h", k, out_q[k], exp_q[k]);
        end
      end
    end
    checks++;
    if (stall_viol != 0) begin
      errors++; $display("FAIL random_stable: got %0d violations want 0", stall_viol);
    end
    checks++;
    if (done_cnt != exp_done || null_cnt != exp_null) begin
      errors++; $display("FAIL random_status: got done=%0d null=%0d want %0d %0d",
                         done_cnt, null_cnt, exp_done, exp_null);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0; s_axis_tuser = '0;
    m_axis_tready = 1'b1; m_drop = 1'b0;
    clear_log();
    test_reset();
    test_single_word();
    test_back_to_back();
    test_sparse_keep();
    test_null_word();
    test_drop();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
